part1_sequencer: RTL and testbench

Sequences a byte stream from an upstream valid/ready source into the `part1` battery-bank solver over its four-phase `data_valid`/`data_ack` handshake. Collects each per-line `result` on `\n` and keeps a running total, line count and error count. Recovers from `data_error` by pulsing `error_clear` and discarding the rest of the offending line. Sits between the input-file/byte source and `part1`, replacing the hand-written handshake loop of the simulation bench so the solver can run stand-alone in hardware.

---
 rtl/part1_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_part1_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/part1_sequencer.sv
// part1_sequencer: drives a valid/ready byte stream into the part1 solver's four-phase
// data_valid/data_ack handshake, accumulating per-line results and recovering from data_error.
module part1_sequencer #(
   parameter int SUM_W   = 48,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       src_data,
   input  logic             src_valid,
   input  logic             src_last,
   output logic             src_ready,
   output logic [7:0]       data_in,
   output logic             data_valid,
   input  logic             data_ack,
   input  logic [31:0]      result,
   input  logic             result_ready,
   input  logic             data_error,
   output logic             error_clear,
   output logic [SUM_W-1:0] total,
   output logic [CNT_W-1:0] line_count,
   output logic [CNT_W-1:0] error_count,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic             overflow
);

   localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
   localparam logic [7:0]        NEWLINE    = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DRIVE    = 3'd2,
      S_WAIT_RES = 3'd3,
      S_RELEASE  = 3'd4,
      S_CLR_ERR  = 3'd5,
      S_SKIP     = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   state_t            state_r;
   state_t            next_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              last_r;
   logic              timeout_s;
   logic              expired_s;
   logic              wait_state_s;
   logic              start_ok_s;
   logic              accum_s;
   logic              err_hit_s;
   logic              dv_nx_s;
   logic              clr_nx_s;
   logic              busy_nx_s;
   logic              done_nx_s;
   logic [SUM_W:0]    sum_s;

   assign wait_state_s = (state_r == S_DRIVE) || (state_r == S_WAIT_RES) ||
                         (state_r == S_RELEASE) || (state_r == S_CLR_ERR);
   assign expired_s    = (wait_cnt_r == WAIT_LIMIT);
   assign start_ok_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
   assign err_hit_s    = data_error && ((state_r == S_DRIVE) || (state_r == S_WAIT_RES) ||
                                        (state_r == S_RELEASE));
   assign accum_s      = (state_r == S_WAIT_RES) && result_ready && !data_error;
   // Extra top bit captures the carry out of total for the sticky overflow flag
   assign sum_s        = {1'b0, total} + {{(SUM_W - 31){1'b0}}, result};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; data_error outranks every other exit, the timeout ranks last
   always_comb begin
      next_s    = state_r;
      timeout_s = 1'b0;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) next_s = S_FETCH;
            else       next_s = state_r;
         end
         S_FETCH: begin
            if (src_valid) next_s = S_DRIVE;
            else           next_s = S_FETCH;
         end
         S_DRIVE: begin
            if (data_error) begin
               next_s = S_CLR_ERR;
            end else if (data_ack) begin
               if (data_in == NEWLINE) next_s = S_WAIT_RES;
               else                    next_s = S_RELEASE;
            end else if (expired_s) begin
               next_s    = S_DONE;
               timeout_s = 1'b1;
            end else begin
               next_s = S_DRIVE;
            end
         end
         S_WAIT_RES: begin
            if (data_error) begin
               next_s = S_CLR_ERR;
            end else if (result_ready) begin
               next_s = S_RELEASE;
            end else if (expired_s) begin
               next_s    = S_DONE;
               timeout_s = 1'b1;
            end else begin
               next_s = S_WAIT_RES;
            end
         end
         S_RELEASE: begin
            if (data_error) begin
               next_s = S_CLR_ERR;
            end else if (!data_ack) begin
               if (last_r) next_s = S_DONE;
               else        next_s = S_FETCH;
            end else if (expired_s) begin
               next_s    = S_DONE;
               timeout_s = 1'b1;
            end else begin
               next_s = S_RELEASE;
            end
         end
         S_CLR_ERR: begin
            if (!data_error && !data_ack) begin
               if (last_r)                  next_s = S_DONE;
               else if (data_in == NEWLINE) next_s = S_FETCH;
               else                         next_s = S_SKIP;
            end else if (expired_s) begin
               next_s    = S_DONE;
               timeout_s = 1'b1;
            end else begin
               next_s = S_CLR_ERR;
            end
         end
         S_SKIP: begin
            if (src_valid && src_last)                 next_s = S_DONE;
            else if (src_valid && src_data == NEWLINE) next_s = S_FETCH;
            else                                       next_s = S_SKIP;
         end
         default: begin
            next_s = S_IDLE;
         end
      endcase
   end

   // Output decode: src_ready from the current state, the rest from the next state so they register cleanly
   always_comb begin
      src_ready = 1'b0;
      dv_nx_s   = 1'b0;
      clr_nx_s  = 1'b0;
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_r)
         S_FETCH, S_SKIP: src_ready = 1'b1;
         default:         src_ready = 1'b0;
      endcase
      case (next_s)
         S_IDLE: begin
            busy_nx_s = 1'b0;
         end
         S_DONE: begin
            done_nx_s = 1'b1;
         end
         S_DRIVE, S_WAIT_RES: begin
            dv_nx_s   = 1'b1;
            busy_nx_s = 1'b1;
         end
         S_CLR_ERR: begin
            clr_nx_s  = 1'b1;
            busy_nx_s = 1'b1;
         end
         default: begin
            busy_nx_s = 1'b1;
         end
      endcase
   end

   // Wait counter restarts on every state change and runs only while waiting on part1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (next_s != state_r) begin
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (wait_state_s) begin
         wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Registered handshake outputs, byte capture, accumulators and sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_in     <= 8'h00;
         last_r      <= 1'b0;
         data_valid  <= 1'b0;
         error_clear <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         total       <= {SUM_W{1'b0}};
         line_count  <= {CNT_W{1'b0}};
         error_count <= {CNT_W{1'b0}};
         timeout_err <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         data_valid  <= dv_nx_s;
         error_clear <= clr_nx_s;
         busy        <= busy_nx_s;
         done        <= done_nx_s;
         if (state_r == S_FETCH && src_valid) begin
            data_in <= src_data;
            last_r  <= src_last;
         end
         if (start_ok_s) begin
            total       <= {SUM_W{1'b0}};
            line_count  <= {CNT_W{1'b0}};
            error_count <= {CNT_W{1'b0}};
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
         end else begin
            if (accum_s) begin
               total      <= sum_s[SUM_W-1:0];
               line_count <= line_count + CNT_W'(1);
               if (sum_s[SUM_W]) overflow <= 1'b1;
            end
            if (err_hit_s) error_count <= error_count + CNT_W'(1);
            if (timeout_s) timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_part1_sequencer.sv
// Directed bench for part1_sequencer: a byte source, a part1 responder and a line-level
// model predicting delivered bytes, running total, line and error counts.
module tb_part1_sequencer;

   localparam int SUM_W   = 33;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 16;
   localparam longint unsigned MOD = 64'd1 << SUM_W;

   logic             clk          = 1'b0;
   logic             rst          = 1'b0;
   logic             start        = 1'b0;
   logic [7:0]       src_data     = 8'h00;
   logic             src_valid    = 1'b0;
   logic             src_last     = 1'b0;
   logic             src_ready;
   logic [7:0]       data_in;
   logic             data_valid;
   logic             data_ack     = 1'b0;
   logic [31:0]      result       = 32'h0;
   logic             result_ready = 1'b0;
   logic             data_error   = 1'b0;
   logic             error_clear;
   logic [SUM_W-1:0] total;
   logic [CNT_W-1:0] line_count;
   logic [CNT_W-1:0] error_count;
   logic             busy;
   logic             done;
   logic             timeout_err;
   logic             overflow;

   always #5 clk = ~clk;

   part1_sequencer #(.SUM_W(SUM_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
      .data_in(data_in), .data_valid(data_valid), .data_ack(data_ack),
      .result(result), .result_ready(result_ready), .data_error(data_error),
      .error_clear(error_clear), .total(total), .line_count(line_count),
      .error_count(error_count), .busy(busy), .done(done),
      .timeout_err(timeout_err), .overflow(overflow)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  src_q[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_rx[$];
   logic [31:0] res_q[$];
   logic [31:0] exp_res[$];
   bit          gate_en, prev_valid, prev_ready, no_ack, held, seen, dv_prev, m_ovf;
   int          cyc, hold_nl, nl_cnt, err_hold, m_lines, m_errs;
   logic [7:0]  err_byte;
   longint unsigned m_total;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: at the falling edge check the model, run the responder and drive the source.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (prev_valid && prev_ready && src_q.size() > 0) void'(src_q.pop_front());
      if (!rst) begin
         if (line_count == CNT_W'(m_lines + 1) && m_lines < exp_res.size()) begin
            m_total = m_total + exp_res[m_lines];
            if (m_total >= MOD) begin
               m_total = m_total - MOD;
               m_ovf   = 1'b1;
            end
            m_lines++;
         end
         check("line_count", line_count, m_lines);
         check("total", total, m_total);
         check("overflow", overflow, m_ovf);
         check("error_count", error_count, m_errs);
         check("error_clear", error_clear, data_error);
         check("dv_and_clear", data_valid & error_clear, 1'b0);
         if (data_valid && !dv_prev) check("dv_rise_ack_low", data_ack, 1'b0);
         if (src_ready) check("ready_when_busy", busy, 1'b1);
         dv_prev = data_valid;
         // part1 responder
         if (err_hold > 0) begin
            err_hold--;
            if (err_hold == 0) data_error = 1'b0;
         end
         if (!data_valid) begin
            seen = 1'b0;
            if (data_ack) begin
               data_ack     = 1'b0;
               result_ready = 1'b0;
            end
         end else if (!seen) begin
            seen = 1'b1;
            rx_q.push_back(data_in);
            if (data_in == err_byte) begin
               data_error = 1'b1;
               err_hold   = 3;
               m_errs++;
            end else if (!no_ack) begin
               data_ack = 1'b1;
               if (data_in == 8'h0A) begin
                  result = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
                  if (nl_cnt == hold_nl) held = 1'b1;
                  else                   result_ready = 1'b1;
                  nl_cnt++;
               end
            end
         end
      end
      if (src_q.size() > 0 && (!gate_en || ((cyc / 3) % 2) == 0)) begin
         src_valid = 1'b1;
         src_data  = src_q[0];
         src_last  = (src_q.size() == 1);
      end else begin
         src_valid = 1'b0;
         src_data  = 8'h00;
         src_last  = 1'b0;
      end
      prev_valid = src_valid;
      prev_ready = src_ready;
      @(posedge clk);
      #2;
   endtask

   task automatic setup(input string s, input bit gate, input logic [7:0] eb,
                        input bit noack, input int hnl);
      bit skip;
      src_q.delete();
      rx_q.delete();
      exp_rx.delete();
      gate_en = gate; err_byte = eb; no_ack = noack; hold_nl = hnl;
      nl_cnt = 0; held = 1'b0; prev_valid = 1'b0;
      skip = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
         src_q.push_back(s[i]);
         if (skip) begin
            if (s[i] == 8'h0A) skip = 1'b0;
         end else begin
            exp_rx.push_back(s[i]);
            if (s[i] == eb) skip = 1'b1;
         end
      end
   endtask

   task automatic model_clear();
      m_total = 0; m_lines = 0; m_errs = 0; m_ovf = 1'b0;
   endtask

   task automatic run_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
      model_clear();
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done && k < 3000) begin
         cycle();
         k++;
      end
      check({name, "_done"}, done, 1'b1);
   endtask

   task automatic check_rx(input string name);
      check({name, "_rx_len"}, rx_q.size(), exp_rx.size());
      for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
         check({name, "_rx_byte"}, rx_q[i], exp_rx[i]);
   endtask

   initial begin
      int k;
      model_clear();
      hold_nl = -1; err_byte = 8'hFF;
      #1 rst = 1'b1;
      #1;
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_data_in", data_in, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_src_ready", src_ready, 1'b0);
      check("rst_total", total, 0);
      check("rst_flags", {timeout_err, overflow, error_clear}, 3'b000);
      repeat (2) cycle();
      rst = 1'b0;

      // two clean lines
      setup("987\n12\n", 1'b0, 8'hFF, 1'b0, -1);
      res_q = {32'd98, 32'd12}; exp_res = res_q;
      run_start();
      wait_done("basic");
      check("basic_total", total, 110);
      check("basic_lines", line_count, 2);
      check("basic_errors", error_count, 0);
      check_rx("basic");

      // same stream with upstream stalls
      setup("987\n12\n", 1'b1, 8'hFF, 1'b0, -1);
      res_q = {32'd98, 32'd12}; exp_res = res_q;
      run_start();
      wait_done("bp");
      check("bp_total", total, 110);
      check("bp_lines", line_count, 2);
      check_rx("bp");

      // error on 'x': rest of line 1 discarded
      setup("9x1\n45\n", 1'b0, 8'h78, 1'b0, -1);
      res_q = {32'd45}; exp_res = res_q;
      run_start();
      wait_done("err");
      check("err_total", total, 45);
      check("err_lines", line_count, 1);
      check("err_errors", error_count, 1);
      check("err_rx_count", rx_q.size(), 5);
      check_rx("err");

      // carry out of a 33-bit total
      setup("1\n2\n3\n", 1'b0, 8'hFF, 1'b0, -1);
      res_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; exp_res = res_q;
      run_start();
      wait_done("ovf");
      check("ovf_total", total, 64'h0_FFFF_FFFD);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_lines", line_count, 3);

      // responder never acks
      setup("5\n", 1'b0, 8'hFF, 1'b1, -1);
      exp_res.delete();
      run_start();
      k = 0;
      while (!data_valid && k < 100) begin
         cycle();
         k++;
      end
      check("to_dv_seen", data_valid, 1'b1);
      repeat (TIMEOUT - 1) cycle();
      check("to_done_early", done, 1'b0);
      check("to_flag_early", timeout_err, 1'b0);
      check("to_dv_hold", data_valid, 1'b1);
      cycle();
      check("to_done", done, 1'b1);
      check("to_flag", timeout_err, 1'b1);
      check("to_dv_low", data_valid, 1'b0);
      check("to_busy", busy, 1'b0);

      // reset while waiting for the second result
      setup("7\n8\n", 1'b0, 8'hFF, 1'b0, 1);
      res_q = {32'd7, 32'd8}; exp_res = res_q;
      run_start();
      k = 0;
      while (!held && k < 200) begin
         cycle();
         k++;
      end
      check("rs_held", held, 1'b1);
      check("rs_total_before", total, 7);
      check("rs_busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("rs_dv", data_valid, 1'b0);
      check("rs_busy", busy, 1'b0);
      check("rs_total", total, 0);
      check("rs_lines", line_count, 0);
      data_ack = 1'b0; result_ready = 1'b0; data_error = 1'b0;
      seen = 1'b0; err_hold = 0; dv_prev = 1'b0;
      src_q.delete();
      model_clear();
      repeat (2) cycle();
      rst = 1'b0;
      setup("12\n", 1'b0, 8'hFF, 1'b0, -1);
      res_q = {32'd12}; exp_res = res_q;
      run_start();
      wait_done("rerun");
      check("rerun_total", total, 12);
      check("rerun_lines", line_count, 1);
      check_rx("rerun");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
